// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned SC_W    = 16;

    // Per-stage hold vectors: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam logic [STALL_W-1:0] StallNone = 6'b000000;
    localparam logic [STALL_W-1:0] StallId   = 6'b000111;
    localparam logic [STALL_W-1:0] StallEx   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: per-stage stall vector, multi-cycle execute sequencing,
// registered flush pulse and a saturating stalled-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                ex_start,
    input  logic [CNT_W-1:0]    ex_len,
    input  logic                flush_req,
    output logic [STALL_W-1:0]  stall,
    output logic                ex_done,
    output logic                flush,
    output logic                busy,
    output logic [SC_W-1:0]     stall_cycles
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic [STALL_W-1:0] stall_raw;
    logic [STALL_W-1:0] req_stall;
    logic               done_raw;
    logic               multi_op;

    // A start with length 0 or 1 completes in place; 2+ needs MULTI
    assign multi_op  = ex_start && (ex_len >= 6'd2);
    assign req_stall = stallreq_ex ? StallEx : (stallreq_id ? StallId : StallNone);

    // State, countdown, flush pulse and stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= (state_d == FLUSH);
            sc_q    <= sc_d;
        end
    end

    // Next-state and countdown; flush_req overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (multi_op) begin
                    state_d = MULTI;
                    cnt_d   = ex_len - 6'd1;
                end
            end
            MULTI: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (cnt_q == 6'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            FLUSH: begin
                cnt_d   = '0;
                state_d = flush_req ? FLUSH : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall vector and completion pulse for the current state
    always_comb begin
        stall_raw = StallNone;
        done_raw  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // a start coinciding with flush_req is dropped entirely
                stall_raw = (multi_op && !flush_req) ? StallEx : req_stall;
                done_raw  = ex_start && (ex_len < 6'd2) && !flush_req;
            end
            MULTI: begin
                if (cnt_q != 6'd1) begin
                    stall_raw = StallEx;
                end else begin
                    stall_raw = req_stall;
                    done_raw  = !flush_req;
                end
            end
            default: begin
                stall_raw = StallNone;
                done_raw  = 1'b0;
            end
        endcase
    end

    // Saturating count of cycles with any stage held
    always_comb begin
        sc_d = sc_q;
        if ((stall != StallNone) && (sc_q != '1)) begin
            sc_d = sc_q + 16'd1;
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign stall        = rst ? stall_raw : StallNone;
    assign ex_done      = rst & done_raw;
    assign busy         = rst & (state_q == MULTI);
    assign flush        = flush_q;
    assign stall_cycles = sc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: cycle table with scoreboard plus
// hand-written reset and saturation sequences.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic        id;
        logic        ex;
        logic        start;
        logic [5:0]  len;
        logic        freq;
        logic [5:0]  e_stall;
        logic        e_done;
        logic        e_flush;
        logic        e_busy;
        logic [15:0] e_sc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, ex_start, flush_req;
    logic [5:0]  ex_len;
    logic [5:0]  stall;
    logic        ex_done, flush, busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    vec_t vecs[28];
    vec_t sb[$];

    pipeline_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .ex_start     (ex_start),
        .ex_len       (ex_len),
        .flush_req    (flush_req),
        .stall        (stall),
        .ex_done      (ex_done),
        .flush        (flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (%0d): got %h expected %h", nm, tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic id, input logic ex, input logic st, input logic [5:0] len,
                                input logic fr, input logic [5:0] es, input logic ed, input logic ef,
                                input logic eb, input logic [15:0] esc);
        vec_t v;
        v.id = id; v.ex = ex; v.start = st; v.len = len; v.freq = fr;
        v.e_stall = es; v.e_done = ed; v.e_flush = ef; v.e_busy = eb; v.e_sc = esc;
        return v;
    endfunction

    task automatic drive(input logic id, input logic ex, input logic st, input logic [5:0] len, input logic fr);
        stallreq_id = id; stallreq_ex = ex; ex_start = st; ex_len = len; flush_req = fr;
    endtask

    initial begin
        vec_t e;
        logic seen_done;
        //               id ex st len fr  stall      done fl busy sc
        vecs[0]  = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 6'd0,  0, 6'b000111, 0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd1);
        vecs[3]  = mk(0, 0, 1, 6'd5,  0, 6'b001111, 0, 0, 0, 16'd1);
        vecs[4]  = mk(0, 0, 0, 6'd0,  0, 6'b001111, 0, 0, 1, 16'd2);
        vecs[5]  = mk(1, 0, 1, 6'd3,  0, 6'b001111, 0, 0, 1, 16'd3);
        vecs[6]  = mk(0, 0, 0, 6'd0,  0, 6'b001111, 0, 0, 1, 16'd4);
        vecs[7]  = mk(0, 0, 0, 6'd0,  0, 6'b000000, 1, 0, 1, 16'd5);
        vecs[8]  = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd5);
        vecs[9]  = mk(0, 0, 1, 6'd1,  0, 6'b000000, 1, 0, 0, 16'd5);
        vecs[10] = mk(0, 0, 1, 6'd0,  0, 6'b000000, 1, 0, 0, 16'd5);
        vecs[11] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd5);
        vecs[12] = mk(1, 0, 1, 6'd5,  1, 6'b000111, 0, 0, 0, 16'd5);
        vecs[13] = mk(1, 0, 0, 6'd0,  0, 6'b000000, 0, 1, 0, 16'd6);
        vecs[14] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd6);
        vecs[15] = mk(0, 0, 1, 6'd2,  0, 6'b001111, 0, 0, 0, 16'd6);
        vecs[16] = mk(0, 1, 0, 6'd0,  0, 6'b001111, 1, 0, 1, 16'd7);
        vecs[17] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd8);
        vecs[18] = mk(0, 0, 1, 6'd10, 0, 6'b001111, 0, 0, 0, 16'd8);
        vecs[19] = mk(0, 0, 0, 6'd0,  0, 6'b001111, 0, 0, 1, 16'd9);
        vecs[20] = mk(0, 0, 0, 6'd0,  1, 6'b001111, 0, 0, 1, 16'd10);
        vecs[21] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 1, 0, 16'd11);
        vecs[22] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd11);
        vecs[23] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd11);
        vecs[24] = mk(0, 0, 0, 6'd0,  1, 6'b000000, 0, 0, 0, 16'd11);
        vecs[25] = mk(0, 0, 0, 6'd0,  1, 6'b000000, 0, 1, 0, 16'd11);
        vecs[26] = mk(0, 0, 1, 6'd5,  0, 6'b000000, 0, 1, 0, 16'd11);
        vecs[27] = mk(0, 0, 0, 6'd0,  0, 6'b000000, 0, 0, 0, 16'd11);

        // Reset with requests active: outputs must be gated low
        rst = 1'b0;
        drive(1, 1, 1, 6'd1, 0);
        repeat (2) @(negedge clk);
        chk("reset_stall", 0, 32'(stall), 32'd0);
        chk("reset_done", 0, 32'(ex_done), 32'd0);
        chk("reset_sc", 0, 32'(stall_cycles), 32'd0);
        drive(0, 0, 0, 6'd0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Cycle table through the scoreboard
        for (int i = 0; i < 28; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].id, vecs[i].ex, vecs[i].start, vecs[i].len, vecs[i].freq);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk("stall", i, 32'(stall), 32'(e.e_stall));
            chk("ex_done", i, 32'(ex_done), 32'(e.e_done));
            chk("flush", i, 32'(flush), 32'(e.e_flush));
            chk("busy", i, 32'(busy), 32'(e.e_busy));
            chk("stall_cycles", i, 32'(stall_cycles), 32'(e.e_sc));
        end

        // Asynchronous reset in the middle of a multi-cycle op
        @(posedge clk); #1;
        drive(0, 0, 1, 6'd10, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 6'd0, 0);
        @(posedge clk); #1;
        chk("mid_busy_before", 0, 32'(busy), 32'd1);
        #2;
        drive(1, 1, 0, 6'd0, 0);
        rst = 1'b0;
        #1;
        chk("async_stall", 0, 32'(stall), 32'd0);
        chk("async_busy", 0, 32'(busy), 32'd0);
        chk("async_done", 0, 32'(ex_done), 32'd0);
        chk("async_sc", 0, 32'(stall_cycles), 32'd0);
        @(posedge clk); #3;
        drive(0, 0, 0, 6'd0, 0);
        rst = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ex_done || busy) seen_done = 1'b1;
        end
        chk("no_done_after_reset", 0, 32'(seen_done), 32'd0);
        chk("sc_after_reset", 0, 32'(stall_cycles), 32'd0);

        // Saturation of the stall counter
        @(posedge clk); #1;
        drive(0, 1, 0, 6'd0, 0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sc_near_max", 0, 32'(stall_cycles), 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk("sc_max", 0, 32'(stall_cycles), 32'hFFFF);
        repeat (4465) @(posedge clk);
        @(negedge clk);
        chk("sc_saturated", 0, 32'(stall_cycles), 32'hFFFF);
        chk("sat_stall", 0, 32'(stall), 32'b001111);
        drive(0, 0, 0, 6'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
